// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one transaction at a time.
// Optional macro ARB_STARVE_GUARD_EN lets a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   fetch_first;
  logic   flush_q;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fetch_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Counts data wins that left a fetch waiting; any break in that run restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (!fetch_first) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_gnt) begin
          state_d = BUSY_D;
        end else if (i_gnt) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data wins ties because it belongs to the older instruction, unless the starvation guard trips.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    mem_req = 1'b0;
    busy    = 1'b0;
    if (state_q == IDLE) begin
      if (rst_n) begin
        if (d_req && !(i_req && fetch_first)) begin
          d_gnt = 1'b1;
        end else if (i_req) begin
          i_gnt = 1'b1;
        end
      end
    end else begin
      mem_req = 1'b1;
      busy    = 1'b1;
    end
  end

  // A flush seen at any point of a fetch, including its final cycle, kills that response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      flush_q   <= 1'b0;
    end else begin
      if (d_gnt) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (i_gnt) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end

      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      if (state_q == BUSY_I && mem_ready && !(flush_q || i_flush)) begin
        i_rvalid <= 1'b1;
        i_rdata  <= mem_rdata;
      end

      if (state_q == BUSY_D && mem_ready) begin
        d_rvalid <= 1'b1;
        if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end

      if (state_q == BUSY_I && !mem_ready) begin
        flush_q <= flush_q | i_flush;
      end else begin
        flush_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: fetch, tie-break, store, flush, reset abort, starvation.
// Inputs change 1ns after a rising edge; outputs are checked 2ns after it.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks;
  int errors;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_flush(i_flush),
    .i_gnt(i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int grants_seen;
    int cycles;
    logic [1:0] grant_seq [5];
    logic [1:0] expect_seq [5];

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    i_req     = 1'b1;
    i_addr    = '0;
    i_flush   = 1'b0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state, with both requests high to prove grants stay masked.
    applyStimulus();
    applyStimulus();
    settle();
    checkOutput("rst_i_gnt", i_gnt, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rvalids", {i_rvalid, d_rvalid}, 0);
    checkOutput("rst_rdata", {i_rdata, d_rdata}, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    applyStimulus();
    rst_n = 1'b1;

    // Single fetch at minimum latency.
    applyStimulus();
    i_req  = 1'b1;
    i_addr = 32'h100;
    settle();
    checkOutput("f_i_gnt", {i_gnt, d_gnt}, 2'b10);
    checkOutput("f_mem_req_n", mem_req, 0);
    applyStimulus();
    i_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    checkOutput("f_mem_req", {mem_req, mem_we, busy}, 3'b101);
    checkOutput("f_mem_addr", mem_addr, 32'h100);
    checkOutput("f_rvalid_early", i_rvalid, 0);
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("f_i_rvalid", i_rvalid, 1);
    checkOutput("f_i_rdata", i_rdata, 32'hDEADBEEF);
    checkOutput("f_busy_idle", busy, 0);
    applyStimulus();
    settle();
    checkOutput("f_rvalid_pulse", i_rvalid, 0);

    // Simultaneous load and fetch: data goes first.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h200;
    i_req  = 1'b1;
    i_addr = 32'h104;
    settle();
    checkOutput("tie_gnt", {i_gnt, d_gnt}, 2'b01);
    applyStimulus();
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h11112222;
    settle();
    checkOutput("tie_d_addr", mem_addr, 32'h200);
    checkOutput("tie_no_gnt_busy", {i_gnt, d_gnt}, 2'b00);
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("tie_d_rvalid", {d_rvalid, i_rvalid}, 2'b10);
    checkOutput("tie_d_rdata", d_rdata, 32'h11112222);
    checkOutput("tie_i_gnt", {i_gnt, d_gnt}, 2'b10);
    applyStimulus();
    i_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h33334444;
    settle();
    checkOutput("tie_i_addr", {mem_we, mem_addr}, {1'b0, 32'h104});
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("tie_i_rvalid", {i_rvalid, d_rvalid}, 2'b10);
    checkOutput("tie_i_rdata", i_rdata, 32'h33334444);

    // Store with the memory holding off for three cycles.
    applyStimulus();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'h55;
    settle();
    checkOutput("st_d_gnt", d_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'hFFFF_FFFF;
      d_wdata   = 32'hFFFF_FFFF;
      mem_ready = (k == 2);
      mem_rdata = 32'h0BAD0BAD;
      settle();
      checkOutput($sformatf("st_hold%0d", k), {mem_req, mem_we, mem_addr, mem_wdata[29:0]},
                  {1'b1, 1'b1, 32'h40, 30'h55});
      checkOutput($sformatf("st_no_rvalid%0d", k), d_rvalid, 0);
    end
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("st_d_rvalid", d_rvalid, 1);
    checkOutput("st_d_rdata_kept", d_rdata, 32'h11112222);
    checkOutput("st_idle", busy, 0);

    // Flush during a fetch suppresses its response only.
    applyStimulus();
    i_req  = 1'b1;
    i_addr = 32'h180;
    settle();
    checkOutput("fl_i_gnt", i_gnt, 1);
    applyStimulus();
    i_req   = 1'b0;
    i_flush = 1'b1;
    applyStimulus();
    i_flush   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("fl_no_rvalid", i_rvalid, 0);
    checkOutput("fl_rdata_kept", i_rdata, 32'h33334444);
    checkOutput("fl_idle", busy, 0);
    i_req  = 1'b1;
    i_addr = 32'h1C0;
    settle();
    checkOutput("fl_next_gnt", i_gnt, 1);
    applyStimulus();
    i_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("fl_next_rvalid", i_rvalid, 1);
    checkOutput("fl_next_rdata", i_rdata, 32'h0BADF00D);

    // Reset in the middle of a load abandons it.
    applyStimulus();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    settle();
    checkOutput("rm_d_gnt", d_gnt, 1);
    applyStimulus();
    d_req = 1'b0;
    rst_n = 1'b0;
    settle();
    checkOutput("rm_busy_before", mem_req, 1);
    applyStimulus();
    rst_n = 1'b1;
    settle();
    checkOutput("rm_after", {mem_req, busy, d_rvalid}, 3'b000);
    checkOutput("rm_addr_clr", mem_addr, 0);
    applyStimulus();
    settle();
    checkOutput("rm_no_rvalid", d_rvalid, 0);
    d_req  = 1'b1;
    d_addr = 32'h304;
    settle();
    checkOutput("rm_new_gnt", d_gnt, 1);
    applyStimulus();
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    settle();
    checkOutput("rm_new_addr", mem_addr, 32'h304);
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("rm_new_rvalid", d_rvalid, 1);
    checkOutput("rm_new_rdata", d_rdata, 32'h12345678);

    // Both requests held with an always-ready memory; record the first five grants.
`ifdef ARB_STARVE_GUARD_EN
    expect_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    expect_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    applyStimulus();
    d_req     = 1'b1;
    d_addr    = 32'h400;
    i_req     = 1'b1;
    i_addr    = 32'h500;
    mem_ready = 1'b1;
    mem_rdata = 32'h0;
    grants_seen = 0;
    cycles      = 0;
    while (grants_seen < 5 && cycles < 40) begin
      settle();
      if (i_gnt || d_gnt) begin
        grant_seq[grants_seen] = {i_gnt, d_gnt};
        grants_seen++;
      end
      cycles++;
      applyStimulus();
    end
    checkOutput("sv_grant_count", grants_seen, 5);
    for (int k = 0; k < grants_seen; k++) begin
      checkOutput($sformatf("sv_grant%0d", k), grant_seq[k], expect_seq[k]);
    end
    d_req = 1'b0;
    i_req = 1'b0;
    applyStimulus();
    applyStimulus();
    mem_ready = 1'b0;
    settle();
    checkOutput("sv_drain_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
